// File: rtl/memory_game_pkg.sv
// Shared constants for the memory game: card geometry, colour format
// and the default pair palette.
package memory_game_pkg;

    localparam int NUM_CARDS = 12;
    localparam int NUM_PAIRS = 6;
    localparam int ADDR_W    = 4;
    localparam int COLOR_W   = 12;
    localparam int PAIR_W    = 3;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef logic [PAIR_W-1:0]  pair_t;
    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t DEF_COLOR0 = 12'hF00;
    localparam color_t DEF_COLOR1 = 12'h0F0;
    localparam color_t DEF_COLOR2 = 12'h00F;
    localparam color_t DEF_COLOR3 = 12'hFF0;
    localparam color_t DEF_COLOR4 = 12'hF0F;
    localparam color_t DEF_COLOR5 = 12'h0FF;

endpackage

// File: rtl/card_color_shuffler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left.
// A zero seed would lock up, so it is replaced by 16'hACE1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    localparam logic [15:0] START = (SEED == 16'h0) ? 16'hACE1 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= START;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/card_color_shuffler.sv
// Builds a random 12-card layout of 6 colour pairs with a Fisher-Yates
// shuffle, then streams the colours into the card colour memory.
module card_color_shuffler
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED   = DEFAULT_SEED,
    parameter color_t      COLOR0 = DEF_COLOR0,
    parameter color_t      COLOR1 = DEF_COLOR1,
    parameter color_t      COLOR2 = DEF_COLOR2,
    parameter color_t      COLOR3 = DEF_COLOR3,
    parameter color_t      COLOR4 = DEF_COLOR4,
    parameter color_t      COLOR5 = DEF_COLOR5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compute_colors_en,
    output logic               compute_done,
    output logic               busy,
    output logic               color_wr_en,
    output logic [ADDR_W-1:0]  color_wr_addr,
    output logic [COLOR_W-1:0] color_wr_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SHUF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [15:0] lfsr;
    logic        unused_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:4];

    // Folding r back below i+1 keeps j in 0..i without a divider.
    function automatic addr_t pick_j(input logic [3:0] rnd, input addr_t i);
        logic [3:0] mask;
        logic [3:0] r;
        if (i >= 4'd8) begin
            mask = 4'hF;
        end else if (i >= 4'd4) begin
            mask = 4'h7;
        end else if (i >= 4'd2) begin
            mask = 4'h3;
        end else begin
            mask = 4'h1;
        end
        r = rnd & mask;
        return (r <= i) ? r : r - (i + 4'd1);
    endfunction

    function automatic color_t pal(input pair_t p);
        color_t c;
        case (p)
            3'd0:    c = COLOR0;
            3'd1:    c = COLOR1;
            3'd2:    c = COLOR2;
            3'd3:    c = COLOR3;
            3'd4:    c = COLOR4;
            3'd5:    c = COLOR5;
            default: c = COLOR0;
        endcase
        return c;
    endfunction

    logic [2:0] state_q, state_d;
    addr_t      i_q, i_d;
    addr_t      addr_q, addr_d;
    pair_t      slot_q [NUM_CARDS];
    pair_t      slot_d [NUM_CARDS];
    addr_t      j;

    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       wr_en_q, wr_en_d;
    addr_t      wr_addr_q, wr_addr_d;
    color_t     wr_data_q, wr_data_d;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        addr_d    = addr_q;
        slot_d    = slot_q;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        j         = pick_j(lfsr[3:0], i_q);

        unique case (state_q)
            S_IDLE: begin
                if (compute_colors_en) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                end else begin
                    for (int k = 0; k < NUM_CARDS; k++) begin
                        slot_d[k] = pair_t'(k >> 1);
                    end
                    i_d     = addr_t'(NUM_CARDS - 1);
                    busy_d  = 1'b1;
                    state_d = S_SHUF;
                end
            end
            S_SHUF: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                end else begin
                    slot_d[i_q] = slot_q[j];
                    slot_d[j]   = slot_q[i_q];
                    i_d         = i_q - 4'd1;
                    busy_d      = 1'b1;
                    if (i_q == 4'd1) begin
                        addr_d  = '0;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = pal(slot_q[addr_q]);
                    addr_d    = addr_q + 4'd1;
                    if (addr_q == addr_t'(NUM_CARDS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            addr_q    <= '0;
            slot_q    <= '{default: '0};
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            slot_q    <= slot_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign compute_done  = done_q;
    assign busy          = busy_q;
    assign color_wr_en   = wr_en_q;
    assign color_wr_addr = wr_addr_q;
    assign color_wr_data = wr_data_q;

endmodule

// File: tb/tb_card_color_shuffler.sv
// Bench for card_color_shuffler: timeline reference model plus
// directed start/abort/hold/reset scenarios.
module tb_card_color_shuffler;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [11:0] PAL [6] = '{12'hF00, 12'h0F0, 12'h00F,
                                        12'hFF0, 12'hF0F, 12'h0FF};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        done;
    logic        busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    card_color_shuffler #(.SEED(SEED)) dut (
        .clk               (clk),
        .rst               (rst),
        .compute_colors_en (en),
        .compute_done      (done),
        .busy              (busy),
        .color_wr_en       (wr_en),
        .color_wr_addr     (wr_addr),
        .color_wr_data     (wr_data)
    );

    function automatic logic [15:0] step(input logic [15:0] s);
        logic fb;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    // Layout from the LFSR value seen at the edge that samples the request.
    function automatic logic [143:0] golden(input logic [15:0] l0);
        int          pr [12];
        int          m, r, j, t;
        logic [15:0] s;
        logic [143:0] out;
        for (int k = 0; k < 12; k++) pr[k] = k / 2;
        s = step(step(l0));
        for (int i = 11; i >= 1; i--) begin
            m = (1 << $clog2(i + 1)) - 1;
            r = int'(s[3:0]) & m;
            j = (r <= i) ? r : r - (i + 1);
            t = pr[i]; pr[i] = pr[j]; pr[j] = t;
            s = step(s);
        end
        out = '0;
        for (int k = 0; k < 12; k++) out[k*12 +: 12] = PAL[pr[k]];
        return out;
    endfunction

    function automatic bit pairs_ok(input logic [143:0] c);
        int n [6];
        for (int p = 0; p < 6; p++) n[p] = 0;
        for (int k = 0; k < 12; k++)
            for (int p = 0; p < 6; p++)
                if (c[k*12 +: 12] == PAL[p]) n[p]++;
        for (int p = 0; p < 6; p++)
            if (n[p] != 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: edges elapsed since the request was sampled (-1 = idle).
    int           age    = -1;
    logic [15:0]  m_lfsr = SEED;
    logic [15:0]  l0     = '0;
    logic [143:0] gold   = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc    <= 0;
            age    <= -1;
            m_lfsr <= SEED;
        end else begin
            cyc <= cyc + 1;
            if (age < 0) begin
                if (en) begin
                    age  <= 0;
                    l0   <= m_lfsr;
                    gold <= golden(m_lfsr);
                end
            end else if (!en) begin
                age <= -1;
            end else if (age < 1000) begin
                age <= age + 1;
            end
            m_lfsr <= step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        logic e_wr;
        e_wr = (age >= 13) && (age <= 24);
        chk("busy", 16'(busy), 16'((age >= 1) && (age <= 24)));
        chk("done", 16'(done), 16'(age >= 25));
        chk("wr_en", 16'(wr_en), 16'(e_wr));
        if (e_wr) begin
            chk("wr_addr", 16'(wr_addr), 16'(age - 13));
            chk("wr_data", 16'(wr_data), 16'(gold[(age-13)*12 +: 12]));
        end else begin
            chk("idle_addr", 16'(wr_addr), 16'd0);
            chk("idle_data", 16'(wr_data), 16'd0);
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic capture(input int budget, output logic [143:0] c,
                           output int nw, output int fw, output int fb,
                           output int dc);
        c = '0; nw = 0; fw = -1; fb = -1; dc = -1;
        for (int k = 0; k < budget && dc < 0; k++) begin
            @(negedge clk);
            if (busy && fb < 0) fb = cyc;
            if (wr_en) begin
                if (wr_addr < 4'd12) c[int'(wr_addr)*12 +: 12] = wr_data;
                if (fw < 0) fw = cyc;
                nw++;
            end
            if (done) dc = cyc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [143:0] c, lay_a, gold_a;
        int nw, fw, fb, dc, s, cnt;

        // Reset values and a standard run with en sampled at edge 5
        rst = 1'b0;
        #1;
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_wr_en", 16'(wr_en), 16'd0);
        do_reset();
        wait_cyc(4);
        en = 1'b1;
        capture(60, c, nw, fw, fb, dc);
        chk("t1_l0", l0, 16'hCE1E);
        chk("t1_first_write", 16'(fw), 16'd18);
        chk("t1_write_count", 16'(nw), 16'd12);
        chk("t1_done_cycle", 16'(dc), 16'd30);
        chk("t1_busy_start", 16'(fb), 16'd6);
        chk("t1_pairs", 16'(pairs_ok(c)), 16'd1);
        chk("t1_layout", 16'(c === gold), 16'd1);
        lay_a  = c;
        gold_a = gold;

        // One cycle later start gives a different layout
        do_reset();
        wait_cyc(5);
        en = 1'b1;
        capture(60, c, nw, fw, fb, dc);
        chk("t3_done_cycle", 16'(dc), 16'd31);
        chk("t3_pairs", 16'(pairs_ok(c)), 16'd1);
        chk("t3_layout", 16'(c === gold), 16'd1);
        chk("t3_differs", 16'(c !== lay_a), 16'(gold !== gold_a));

        // Abort during the 4th write
        do_reset();
        wait_cyc(4);
        en = 1'b1;
        cnt = 0;
        while (cyc < 21) begin
            @(negedge clk);
            if (wr_en) cnt++;
        end
        chk("t4_writes_before_abort", 16'(cnt), 16'd4);
        en = 1'b0;
        @(negedge clk);
        chk("t4_no_write_after", 16'(wr_en), 16'd0);
        chk("t4_busy_after", 16'(busy), 16'd0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || wr_en) cnt++;
        end
        chk("t4_quiet", 16'(cnt), 16'd0);
        s = cyc;
        en = 1'b1;
        capture(60, c, nw, fw, fb, dc);
        chk("t4_rerun_writes", 16'(nw), 16'd12);
        chk("t4_rerun_done", 16'(dc - s), 16'd26);
        chk("t4_rerun_pairs", 16'(pairs_ok(c)), 16'd1);

        // Hold en after done: no restart
        cnt = 0;
        nw  = 0;
        repeat (100) begin
            @(negedge clk);
            if (!done) cnt++;
            if (wr_en) nw++;
        end
        chk("t5_done_held", 16'(cnt), 16'd0);
        chk("t5_no_writes", 16'(nw), 16'd0);
        en = 1'b0;
        @(negedge clk);
        chk("t5_done_drop", 16'(done), 16'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_restart_busy", 16'(busy), 16'd1);
        capture(60, c, nw, fw, fb, dc);
        chk("t5_restart_writes", 16'(nw), 16'd12);
        chk("t5_restart_pairs", 16'(pairs_ok(c)), 16'd1);

        // Asynchronous reset in the middle of the shuffle
        do_reset();
        wait_cyc(4);
        en = 1'b1;
        wait_cyc(9);
        chk("t6_busy_before", 16'(busy), 16'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", 16'(busy), 16'd0);
        chk("t6_rst_done", 16'(done), 16'd0);
        chk("t6_rst_wr", 16'({wr_en, wr_addr, wr_data[10:0]}), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        capture(60, c, nw, fw, fb, dc);
        chk("t6_done_cycle", 16'(dc), 16'd26);
        chk("t6_first_write", 16'(fw), 16'd14);
        chk("t6_write_count", 16'(nw), 16'd12);
        chk("t6_layout", 16'(c === gold), 16'd1);
        chk("t6_pairs", 16'(pairs_ok(c)), 16'd1);

        en = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
